// File: rtl/lsu_axi_if.sv
// AXI4-Lite read/write channel bundle between the load/store unit (master) and memory (slave).
interface lsu_axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_axi.sv
// Multi-cycle load/store unit: one outstanding AXI4-Lite access, lane steering and load extension.
// state | meaning
// IDLE  | ready for a request
// AR    | read address offered
// R     | waiting for read data
// WR    | write address/data offered, each dropped after its handshake
// B     | waiting for write response
// DONE  | result held until downstream accepts
module lsu_axi #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [3:0]                in_op,
  input  logic [DATA_WIDTH-1:0]     in_wdata,
  input  logic                      in_regw,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_rdata,
  output logic                      out_err,
  output logic                      out_regw,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  lsu_axi_if.master                 bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [3:0]                op_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      regw_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;
  logic                      aw_done, w_done;

  logic [2:0]            low_mask;
  logic                  misaligned;
  logic [OFFW-1:0]       off;
  logic [DATA_WIDTH-1:0] rshift, fmask, smask, load_ext;
  logic                  aw_fire, w_fire;

  always_comb begin
    case (in_op[1:0])
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
    misaligned = (|(in_addr[2:0] & low_mask)) || ((in_op[1:0] == 2'd3) && (DATA_WIDTH == 32));
  end

  assign off = addr_q[OFFW-1:0];

  // fmask covers the loaded field; smask is its top bit, used as the sign.
  always_comb begin
    rshift   = bus.rdata >> {off, 3'b000};
    fmask    = ~({DATA_WIDTH{1'b1}} << (8 << op_q[1:0]));
    smask    = fmask ^ (fmask >> 1);
    load_ext = (rshift & fmask) | ((!op_q[2] && (|(rshift & smask))) ? ~fmask : '0);
  end

  assign aw_fire = bus.awvalid && bus.awready;
  assign w_fire  = bus.wvalid && bus.wready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = misaligned ? S_DONE : (in_op[3] ? S_WR : S_AR);
      S_AR:   if (bus.arready) state_nxt = S_R;
      S_R:    if (bus.rvalid) state_nxt = S_DONE;
      S_WR:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = S_B;
      S_B:    if (bus.bvalid) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      regw_q  <= 1'b0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (in_valid) begin
          addr_q  <= in_addr;
          op_q    <= in_op;
          wdata_q <= in_wdata;
          regw_q  <= in_regw;
          rd_q    <= in_rd;
          rdata_q <= '0;
          err_q   <= misaligned;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        S_R: if (bus.rvalid) begin
          err_q   <= (bus.rresp != 2'b00);
          rdata_q <= (bus.rresp != 2'b00) ? '0 : load_ext;
        end
        S_WR: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        S_B: if (bus.bvalid) err_q <= (bus.bresp != 2'b00);
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign out_rdata   = rdata_q;
  assign out_err     = err_q;
  assign out_regw    = regw_q && !err_q;
  assign out_rd      = rd_q;

  assign bus.araddr  = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  assign bus.arvalid = (state == S_AR);
  assign bus.rready  = (state == S_R);
  assign bus.awaddr  = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  assign bus.awvalid = (state == S_WR) && !aw_done;
  assign bus.wvalid  = (state == S_WR) && !w_done;
  assign bus.wdata   = wdata_q << {off, 3'b000};
  assign bus.wstrb   = (~({NB{1'b1}} << (1 << op_q[1:0]))) << off;
  assign bus.bready  = (state == S_B);
endmodule

// File: tb/tb_lsu_axi.sv
// Bench for lsu_axi: 32-bit unit against a delay-programmable slave, 64-bit unit against a zero-wait slave.
module tb_lsu_axi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  lsu_axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b32 ();
  lsu_axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) b64 ();

  logic        in_valid, in_ready, in_regw, out_valid, out_ready, out_err, out_regw;
  logic [31:0] in_addr, in_wdata, out_rdata;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, out_rd;

  logic        x_in_valid, x_in_ready, x_in_regw, x_out_valid, x_out_ready, x_out_err, x_out_regw;
  logic [31:0] x_in_addr;
  logic [63:0] x_in_wdata, x_out_rdata;
  logic [3:0]  x_in_op;
  logic [4:0]  x_in_rd, x_out_rd;

  lsu_axi #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_op(in_op), .in_wdata(in_wdata), .in_regw(in_regw), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .out_regw(out_regw), .out_rd(out_rd), .bus(b32));

  lsu_axi #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready), .in_addr(x_in_addr),
    .in_op(x_in_op), .in_wdata(x_in_wdata), .in_regw(x_in_regw), .in_rd(x_in_rd),
    .out_valid(x_out_valid), .out_ready(x_out_ready), .out_rdata(x_out_rdata), .out_err(x_out_err),
    .out_regw(x_out_regw), .out_rd(x_out_rd), .bus(b64));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: byte-by-byte lane selection and extension.
  function automatic logic [63:0] m_load(input int dw, input logic [63:0] addr, input logic [3:0] op,
                                         input logic [63:0] mem);
    int nb, off, sz;
    logic [63:0] v;
    nb = dw / 8;
    off = int'(addr % nb);
    sz = 1 << op[1:0];
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = mem[8*(off+i) +: 8];
    if (!op[2] && v[8*sz-1]) for (int i = 8*sz; i < dw; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic m_misaligned(input int dw, input logic [63:0] addr, input logic [3:0] op);
    int sz;
    sz = 1 << op[1:0];
    return ((addr % sz) != 0) || (sz == 8 && dw == 32);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] addr, input logic [31:0] wd);
    return wd << (8 * (addr % 4));
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [31:0] addr, input logic [3:0] op);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < (1 << op[1:0]); i++) s[(addr % 4) + i] = 1'b1;
    return s;
  endfunction

  // Slave configuration and scoreboard state
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
  logic [1:0]  rresp_c = 2'b00, bresp_c = 2'b00;
  logic [31:0] mem32 = 32'h80FF_1234;
  logic [63:0] mem64 = 64'h8765_4321_0000_0000;

  logic [31:0] e_rdata, e_baddr, e_wdata;
  logic [3:0]  e_wstrb;
  logic        e_err, e_regw;
  logic [4:0]  e_rd;
  logic        busy = 1'b0;
  int ar_hi = 0, aw_hi = 0, w_hi = 0;

  always @(negedge clk) begin
    if (rst) begin
      b32.arready = 0; b32.rvalid = 0; b32.awready = 0; b32.wready = 0; b32.bvalid = 0;
      b32.rdata = '0; b32.rresp = '0; b32.bresp = '0;
      ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    end else begin
      b32.arready = b32.arvalid && (ar_w >= ar_dly); ar_w = b32.arvalid ? ar_w + 1 : 0;
      b32.rvalid  = b32.rready  && (r_w  >= r_dly);  r_w  = b32.rready  ? r_w + 1  : 0;
      b32.awready = b32.awvalid && (aw_w >= aw_dly); aw_w = b32.awvalid ? aw_w + 1 : 0;
      b32.wready  = b32.wvalid  && (w_w  >= w_dly);  w_w  = b32.wvalid  ? w_w + 1  : 0;
      b32.bvalid  = b32.bready  && (b_w  >= b_dly);  b_w  = b32.bready  ? b_w + 1  : 0;
      b32.rdata = mem32; b32.rresp = rresp_c; b32.bresp = bresp_c;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b64.arready = 0; b64.rvalid = 0; b64.awready = 0; b64.wready = 0; b64.bvalid = 0;
      b64.rdata = '0; b64.rresp = '0; b64.bresp = '0;
    end else begin
      b64.arready = b64.arvalid; b64.rvalid = b64.rready;
      b64.awready = b64.awvalid; b64.wready = b64.wvalid; b64.bvalid = b64.bready;
      b64.rdata = mem64; b64.rresp = 2'b00; b64.bresp = 2'b00;
    end
  end

  // Per-cycle comparison of the 32-bit unit against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, !busy);
      if (out_valid && !busy) check("spurious_out_valid", out_valid, 1'b0);
      if (out_valid && busy) begin
        check("out_rdata", out_rdata, e_rdata);
        check("out_err", out_err, e_err);
        check("out_regw", out_regw, e_regw);
        check("out_rd", out_rd, e_rd);
      end
      if (b32.arvalid) begin ar_hi++; check("araddr", b32.araddr, e_baddr); end
      if (b32.awvalid) begin aw_hi++; check("awaddr", b32.awaddr, e_baddr); end
      if (b32.wvalid) begin
        w_hi++;
        check("wdata", b32.wdata, e_wdata);
        check("wstrb", b32.wstrb, e_wstrb);
      end
    end
  end

  task automatic req32(input logic [31:0] addr, input logic [3:0] op, input logic [31:0] wd,
                       input logic regw, input logic [4:0] rd, input int exp_lat, input int exp_ar,
                       input int exp_aw, input int exp_w, input int hold,
                       input logic [31:0] lit, input logic lit_err);
    logic [63:0] ld;
    int lat;
    ld = m_load(32, {32'h0, addr}, op, {32'h0, mem32});
    e_err   = m_misaligned(32, {32'h0, addr}, op) || (!op[3] && rresp_c != 0) || (op[3] && bresp_c != 0);
    e_rdata = (op[3] || e_err) ? 32'h0 : ld[31:0];
    e_regw  = regw && !e_err;
    e_rd    = rd;
    e_baddr = addr & ~32'h3;
    e_wdata = m_wdata(addr, wd);
    e_wstrb = m_wstrb(addr, op);
    ar_hi = 0; aw_hi = 0; w_hi = 0;
    @(negedge clk);
    in_valid = 1'b1; in_addr = addr; in_op = op; in_wdata = wd; in_regw = regw; in_rd = rd;
    @(posedge clk);
    #1 in_valid = 1'b0; busy = 1'b1;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    check("latency", lat, exp_lat);
    check("rdata_literal", out_rdata, lit);
    check("err_literal", out_err, lit_err);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; busy = 1'b0;
    check("arvalid_cycles", ar_hi, exp_ar);
    check("awvalid_cycles", aw_hi, exp_aw);
    check("wvalid_cycles", w_hi, exp_w);
  endtask

  task automatic req64(input logic [31:0] addr, input logic [3:0] op, input int exp_lat,
                       input logic [63:0] lit, input logic lit_err);
    logic [63:0] mdl;
    logic merr;
    int lat;
    merr = m_misaligned(64, {32'h0, addr}, op);
    mdl  = merr ? 64'h0 : m_load(64, {32'h0, addr}, op, mem64);
    @(negedge clk);
    x_in_valid = 1'b1; x_in_addr = addr; x_in_op = op;
    @(posedge clk);
    #1 x_in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (x_out_valid) begin lat = k; break; end
    end
    check("w64_latency", lat, exp_lat);
    check("w64_rdata_model", x_out_rdata, mdl);
    check("w64_rdata_literal", x_out_rdata, lit);
    check("w64_err_model", x_out_err, merr);
    check("w64_err_literal", x_out_err, lit_err);
    check("w64_regw", x_out_regw, !merr);
    x_out_ready = 1'b1;
    @(posedge clk);
    #1 x_out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; out_ready = 0; in_addr = '0; in_op = '0; in_wdata = '0; in_regw = 0; in_rd = '0;
    x_in_valid = 0; x_out_ready = 0; x_in_addr = '0; x_in_op = '0; x_in_wdata = '0;
    x_in_regw = 1'b1; x_in_rd = 5'd3;

    // Pin the model with hand-computed values
    check("model_sbyte", m_load(32, 64'h8000_0003, 4'b0000, 64'h80FF_1234), 64'hFFFF_FF80);
    check("model_ubyte", m_load(32, 64'h8000_0003, 4'b0100, 64'h80FF_1234), 64'h0000_0080);
    check("model_w64", m_load(64, 64'h8000_0004, 4'b0010, 64'h8765_4321_0000_0000), 64'hFFFF_FFFF_8765_4321);
    check("model_wdata", m_wdata(32'h8000_0002, 32'h0000_ABCD), 32'hABCD_0000);
    check("model_wstrb", m_wstrb(32'h8000_0002, 4'b1001), 4'b1100);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_out_rdata", out_rdata, 32'h0);
    check("rst_valids", {b32.arvalid, b32.awvalid, b32.wvalid, b32.rready, b32.bready}, 5'b0);
    @(negedge clk);
    rst = 1'b0;

    req32(32'h8000_0003, 4'b0000, 32'h0, 1'b1, 5'd5, 3, 1, 0, 0, 0, 32'hFFFF_FF80, 1'b0);
    req32(32'h8000_0003, 4'b0100, 32'h0, 1'b1, 5'd6, 3, 1, 0, 0, 0, 32'h0000_0080, 1'b0);
    req32(32'h8000_0002, 4'b0001, 32'h0, 1'b1, 5'd7, 3, 1, 0, 0, 0, 32'hFFFF_80FF, 1'b0);
    ar_dly = 2; r_dly = 1;
    req32(32'h8000_0000, 4'b0010, 32'h0, 1'b1, 5'd8, 6, 3, 0, 0, 0, 32'h80FF_1234, 1'b0);
    ar_dly = 0; r_dly = 0;

    req32(32'h8000_0002, 4'b1001, 32'h0000_ABCD, 1'b0, 5'd9, 3, 0, 1, 1, 0, 32'h0, 1'b0);
    aw_dly = 3;
    req32(32'h8000_0002, 4'b1001, 32'h0000_ABCD, 1'b0, 5'd9, 6, 0, 4, 1, 0, 32'h0, 1'b0);
    aw_dly = 0; w_dly = 3;
    req32(32'h8000_0002, 4'b1001, 32'h0000_ABCD, 1'b0, 5'd9, 6, 0, 1, 4, 0, 32'h0, 1'b0);
    w_dly = 0;
    req32(32'h8000_0001, 4'b1000, 32'h0000_005A, 1'b0, 5'd1, 3, 0, 1, 1, 0, 32'h0, 1'b0);

    req32(32'h8000_0002, 4'b0010, 32'h0, 1'b1, 5'd10, 1, 0, 0, 0, 0, 32'h0, 1'b1);
    req32(32'h8000_0000, 4'b0011, 32'h0, 1'b1, 5'd11, 1, 0, 0, 0, 0, 32'h0, 1'b1);

    rresp_c = 2'b10;
    req32(32'h8000_0000, 4'b0010, 32'h0, 1'b1, 5'd12, 3, 1, 0, 0, 5, 32'h0, 1'b1);
    rresp_c = 2'b00; bresp_c = 2'b11;
    req32(32'h8000_0004, 4'b1010, 32'h1122_3344, 1'b1, 5'd13, 3, 0, 1, 1, 0, 32'h0, 1'b1);
    bresp_c = 2'b00;

    // Reset while a read response is still pending
    r_dly = 10;
    e_baddr = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h8000_0000; in_op = 4'b0010; in_regw = 1'b1; in_rd = 5'd14;
    @(posedge clk);
    #1 in_valid = 1'b0; busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b32.rready) break;
    end
    check("reached_r", b32.rready, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    busy = 1'b0;
    check("mid_rst_valids", {b32.arvalid, b32.awvalid, b32.wvalid, b32.rready, b32.bready}, 5'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    r_dly = 0;
    req32(32'h8000_0001, 4'b0100, 32'h0, 1'b1, 5'd15, 3, 1, 0, 0, 0, 32'h0000_0012, 1'b0);

    req64(32'h8000_0004, 4'b0010, 3, 64'hFFFF_FFFF_8765_4321, 1'b0);
    req64(32'h8000_0004, 4'b0011, 1, 64'h0, 1'b1);
    req64(32'h8000_0008, 4'b0011, 3, 64'h8765_4321_0000_0000, 1'b0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_axi.md
# lsu_axi

Parametrised load/store unit for the NPC execute-to-memory path. It replaces the single-cycle DPI memory access with a multi-cycle AXI4-Lite master that tolerates arbitrary memory latency. It supports 32- or 64-bit data paths, byte-lane strobes, sign/zero extension of loads, misalignment detection and bus-error reporting. It sits between the ALU result and the write-back stage and uses valid/ready handshakes on both sides.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 or 64 are legal.
- ADDR_WIDTH, 32, address width.
- REG_ADDR_WIDTH, 5, destination register index width.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_addr  in  ADDR_WIDTH  effective byte address
- in_op  in  4  [3]=store, [2]=unsigned load, [1:0]=log2 of size (0 byte, 1 half, 2 word, 3 dword; dword legal only when DATA_WIDTH=64)
- in_wdata  in  DATA_WIDTH  store data, right-aligned
- in_regw  in  1  write-back enable, passed through
- in_rd  in  REG_ADDR_WIDTH  destination register, passed through
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_rdata  out  DATA_WIDTH  extended load data; 0 for stores and on error
- out_err  out  1  misaligned access or non-OKAY response
- out_regw / out_rd  out  1 / REG_ADDR_WIDTH  captured pass-through; out_regw forced to 0 when out_err=1
- AXI-Lite read channel: araddr (out, ADDR_WIDTH), arvalid (out), arready (in), rdata (in, DATA_WIDTH), rresp (in, 2), rvalid (in), rready (out)
- AXI-Lite write channel: awaddr (out), awvalid (out), awready (in), wdata (out, DATA_WIDTH), wstrb (out, DATA_WIDTH/8), wvalid (out), wready (in), bresp (in, 2), bvalid (in), bready (out)

## Operation
- Let NB = DATA_WIDTH/8 and off = in_addr mod NB.
- Accepted requests are registered: addr, op, wdata, regw and rd.
- State machine states: IDLE, AR, R, WR, B, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: if addr mod 2^size ≠ 0, or size=3 with DATA_WIDTH=32, go to DONE with err=1 and issue no bus traffic.
  - Otherwise go to AR for a load or WR for a store.
- AR:
  - arvalid=1, araddr = addr with the low log2(NB) bits cleared.
  - On arready go to R.
- R:
  - rready=1.
  - On rvalid, extract the bytes at lane off of size 2^size, then sign-extend (op[2]=0) or zero-extend (op[2]=1) to DATA_WIDTH.
  - err = (rresp≠0); data becomes 0 if err. Go to DONE.
- WR:
  - awvalid and wvalid rise together. awaddr is aligned the same way as araddr.
  - wdata = in_wdata << (8·off).
  - wstrb = ((1<<2^size)−1) << off.
  - Each valid drops independently after its own handshake (aw_done and w_done flags). When both are done, go to B.
  - Handshakes may occur in the same cycle or in either order.
- B:
  - bready=1.
  - On bvalid: err = (bresp≠0), go to DONE.
- DONE:
  - out_valid=1, outputs stable.
  - On out_ready go to IDLE.
  - No new request is accepted in the same cycle (in_ready=0 outside IDLE).
- At most one outstanding transaction. Bus address, data and strobes stay constant while the corresponding valid is high.

## Timing
- Reset: state=IDLE; in_ready=1; out_valid, out_err, arvalid, awvalid, wvalid, rready, bready = 0; out_rdata = 0; aw_done = w_done = 0.
- A reset asserted mid-transaction abandons the transaction. All bus valids are low the cycle after reset; the slave is reset on the same signal.
- Load latency with a zero-wait slave (arready=1 in AR, rvalid=1 in the first R cycle): accept at cycle 0, AR cycle 1, R cycle 2, out_valid cycle 3. Each slave wait cycle adds 1.
- Store latency with a zero-wait slave: accept at 0, WR cycle 1, B cycle 2, out_valid cycle 3.
- Misaligned access: accept at 0, out_valid at cycle 1.
- Throughput: at best one request per 4 cycles with out_ready tied to 1.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or bus inputs to outputs.

## Test plan
- Load, 32-bit, zero-wait slave, addr 0x8000_0003, signed byte, memory word 0x80FF_1234 → araddr 0x8000_0000, out_rdata 0xFFFF_FF80, out_err 0, out_valid at cycle 3. Repeat with unsigned byte → 0x0000_0080.
- Store half, addr 0x8000_0002, in_wdata 0x0000_ABCD → wdata 0xABCD_0000, wstrb 0b1100. Case 1: awready delayed 3 cycles while wready is immediate → wvalid drops after 1 cycle, awvalid after 4, then B. Case 2: swap which of awready/wready is delayed → same result.
- Misaligned word load at 0x8000_0002 → no arvalid ever, out_err 1, out_regw 0, out_valid at cycle 1.
- DATA_WIDTH=64, signed word load at 0x8000_0004, memory 0x8765_4321_0000_0000 → out_rdata 0xFFFF_FFFF_8765_4321. Dword load at 0x8000_0004 → misaligned error.
- Responses and backpressure: rresp=2 (SLVERR) → out_err 1, out_rdata 0. Hold out_ready low 5 cycles → outputs stable and in_ready 0 throughout.
- Assert rst during R with rvalid pending → next cycle all valids low, state IDLE, and a following load completes normally.
